// File: rtl/ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg (package)
// Description : Shared operand-select encodings and constants for the EX
//               operand stage and its forwarding selector.
// Contents    : src_a_sel_e - ALU SrcA select encoding
//               src_b_sel_e - ALU SrcB select encoding
//               SRCB_CONST_FOUR - constant driven on SrcB for PC+4 style ops
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

    typedef enum logic [1:0] {
        SRCA_REG  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2,
        SRCA_RSVD = 2'd3
    } src_a_sel_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_FOUR = 2'd2,
        SRCB_RSVD = 2'd3
    } src_b_sel_e;

    localparam int unsigned SRCB_CONST_FOUR = 4;

endpackage : ex_pkg
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_priority_sel.sv
`default_nettype none
// ============================================================================
// Module      : fwd_priority_sel
// Description : Resolves one source register against NUM_FWD forwarding
//               sources. The lowest-index matching source wins; register
//               index 0 never forwards.
// Ports       : i_rs        - source register index
//               i_regVal    - register-file value used when nothing matches
//               i_fwdValid  - per-source write enable
//               i_fwdRd     - packed per-source destination indices
//               i_fwdData   - packed per-source result values
//               o_value     - resolved operand value
//               o_hit       - a forwarding source supplied o_value
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_priority_sel #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 2
) (
    input  logic [REG_ADDR_W-1:0]         i_rs,
    input  logic [XLEN-1:0]               i_regVal,
    input  logic [NUM_FWD-1:0]            i_fwdValid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] i_fwdRd,
    input  logic [NUM_FWD*XLEN-1:0]       i_fwdData,
    output logic [XLEN-1:0]               o_value,
    output logic                          o_hit
);

    logic [NUM_FWD-1:0] w_match;

    generate
        for (genvar k = 0; k < NUM_FWD; k++) begin : g_match
            assign w_match[k] = i_fwdValid[k]
                              && (i_fwdRd[k*REG_ADDR_W +: REG_ADDR_W] == i_rs)
                              && (i_rs != '0);
        end
    endgenerate

    // Walk from the oldest source down to the youngest so that the
    // lowest-index match is the last assignment and therefore wins.
    always_comb begin
        o_value = i_regVal;
        o_hit   = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_value = i_fwdData[k*XLEN +: XLEN];
                o_hit   = 1'b1;
            end
        end
    end

endmodule : fwd_priority_sel
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_operand_stage
// Description : ID/EX operand register with parametrised forwarding. Holds
//               on stall (while still capturing forwarded values so a
//               retiring producer is not lost), bubbles on flush, and drives
//               ALU SrcA/SrcB plus the store write data.
// Ports       : clk, rst_n            - clock, async active-low reset
//               id_valid_i, id_*_i    - ID stage operand bundle
//               stall_i, flush_i      - pipeline control
//               fwd_valid_i/rd_i/data_i - forwarding sources, index 0 youngest
//               ex_valid_o            - EX holds a valid instruction
//               ex_src_a_o/ex_src_b_o - ALU operands
//               ex_write_data_o       - forwarded rs2 for stores
//               ex_fwd_hit_a_o/b_o    - operand came from a forwarding source
// Revision    : 1.0 - initial release
// ============================================================================
module ex_operand_stage
    import ex_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_FWD    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_valid_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic [XLEN-1:0]               id_rd1_i,
    input  logic [XLEN-1:0]               id_rd2_i,
    input  logic [XLEN-1:0]               id_imm_i,
    input  logic [XLEN-1:0]               id_pc_i,
    input  logic [REG_ADDR_W-1:0]         id_rs1_i,
    input  logic [REG_ADDR_W-1:0]         id_rs2_i,
    input  logic [1:0]                    id_src_a_sel_i,
    input  logic [1:0]                    id_src_b_sel_i,
    input  logic [NUM_FWD-1:0]            fwd_valid_i,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd_i,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data_i,
    output logic                          ex_valid_o,
    output logic [XLEN-1:0]               ex_src_a_o,
    output logic [XLEN-1:0]               ex_src_b_o,
    output logic [XLEN-1:0]               ex_write_data_o,
    output logic                          ex_fwd_hit_a_o,
    output logic                          ex_fwd_hit_b_o
);

    logic                  r_valid;
    logic [XLEN-1:0]       r_rd1;
    logic [XLEN-1:0]       r_rd2;
    logic [XLEN-1:0]       r_imm;
    logic [XLEN-1:0]       r_pc;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    src_a_sel_e            r_selA;
    src_b_sel_e            r_selB;

    logic [XLEN-1:0]       w_fwdA;
    logic [XLEN-1:0]       w_fwdB;
    logic                  w_hitA;
    logic                  w_hitB;
    logic [XLEN-1:0]       w_srcA;
    logic [XLEN-1:0]       w_srcB;

    fwd_priority_sel #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) u_fwdA (
        .i_rs       (r_rs1),
        .i_regVal   (r_rd1),
        .i_fwdValid (fwd_valid_i),
        .i_fwdRd    (fwd_rd_i),
        .i_fwdData  (fwd_data_i),
        .o_value    (w_fwdA),
        .o_hit      (w_hitA)
    );

    fwd_priority_sel #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) u_fwdB (
        .i_rs       (r_rs2),
        .i_regVal   (r_rd2),
        .i_fwdValid (fwd_valid_i),
        .i_fwdRd    (fwd_rd_i),
        .i_fwdData  (fwd_data_i),
        .o_value    (w_fwdB),
        .o_hit      (w_hitB)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_selA  <= SRCA_REG;
            r_selB  <= SRCB_REG;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_selA  <= SRCA_REG;
            r_selB  <= SRCB_REG;
        end else if (stall_i) begin
            // A producer may retire while we wait; keep its result so the
            // operand is still correct once the forwarding path has moved on.
            if (r_valid && w_hitA) begin
                r_rd1 <= w_fwdA;
            end
            if (r_valid && w_hitB) begin
                r_rd2 <= w_fwdB;
            end
        end else begin
            r_valid <= id_valid_i;
            r_rd1   <= id_rd1_i;
            r_rd2   <= id_rd2_i;
            r_imm   <= id_imm_i;
            r_pc    <= id_pc_i;
            r_rs1   <= id_rs1_i;
            r_rs2   <= id_rs2_i;
            r_selA  <= src_a_sel_e'(id_src_a_sel_i);
            r_selB  <= src_b_sel_e'(id_src_b_sel_i);
        end
    end

    always_comb begin
        w_srcA = '0;
        case (r_selA)
            SRCA_REG: w_srcA = w_fwdA;
            SRCA_PC:  w_srcA = r_pc;
            default:  w_srcA = '0;
        endcase
    end

    always_comb begin
        w_srcB = '0;
        case (r_selB)
            SRCB_REG:  w_srcB = w_fwdB;
            SRCB_IMM:  w_srcB = r_imm;
            SRCB_FOUR: w_srcB = XLEN'(SRCB_CONST_FOUR);
            default:   w_srcB = '0;
        endcase
    end

    assign ex_valid_o      = r_valid;
    assign ex_src_a_o      = r_valid ? w_srcA : '0;
    assign ex_src_b_o      = r_valid ? w_srcB : '0;
    // Stores always need rs2, whatever operand B is used for.
    assign ex_write_data_o = r_valid ? w_fwdB : '0;
    assign ex_fwd_hit_a_o  = r_valid && (r_selA == SRCA_REG) && w_hitA;
    assign ex_fwd_hit_b_o  = r_valid && w_hitB;

endmodule : ex_operand_stage
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_operand_stage
// Description : Self-checking bench for ex_operand_stage: directed scenarios
//               with literal expectations followed by randomized traffic
//               compared every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_FWD    = 2;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          idValid = 1'b0;
    logic                          stall = 1'b0;
    logic                          flush = 1'b0;
    logic [XLEN-1:0]               idRd1 = '0;
    logic [XLEN-1:0]               idRd2 = '0;
    logic [XLEN-1:0]               idImm = '0;
    logic [XLEN-1:0]               idPc = '0;
    logic [REG_ADDR_W-1:0]         idRs1 = '0;
    logic [REG_ADDR_W-1:0]         idRs2 = '0;
    logic [1:0]                    idSelA = '0;
    logic [1:0]                    idSelB = '0;
    logic [NUM_FWD-1:0]            fValid = '0;
    logic [REG_ADDR_W-1:0]         fRd   [NUM_FWD];
    logic [XLEN-1:0]               fData [NUM_FWD];
    logic [NUM_FWD*REG_ADDR_W-1:0] fwdRdBus;
    logic [NUM_FWD*XLEN-1:0]       fwdDataBus;

    logic                          exValid;
    logic [XLEN-1:0]               exSrcA;
    logic [XLEN-1:0]               exSrcB;
    logic [XLEN-1:0]               exWd;
    logic                          exHitA;
    logic                          exHitB;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always_comb begin
        fwdRdBus   = '0;
        fwdDataBus = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            fwdRdBus[k*REG_ADDR_W +: REG_ADDR_W] = fRd[k];
            fwdDataBus[k*XLEN +: XLEN]           = fData[k];
        end
    end

    ex_operand_stage #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_FWD    (NUM_FWD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid_i      (idValid),
        .stall_i         (stall),
        .flush_i         (flush),
        .id_rd1_i        (idRd1),
        .id_rd2_i        (idRd2),
        .id_imm_i        (idImm),
        .id_pc_i         (idPc),
        .id_rs1_i        (idRs1),
        .id_rs2_i        (idRs2),
        .id_src_a_sel_i  (idSelA),
        .id_src_b_sel_i  (idSelB),
        .fwd_valid_i     (fValid),
        .fwd_rd_i        (fwdRdBus),
        .fwd_data_i      (fwdDataBus),
        .ex_valid_o      (exValid),
        .ex_src_a_o      (exSrcA),
        .ex_src_b_o      (exSrcB),
        .ex_write_data_o (exWd),
        .ex_fwd_hit_a_o  (exHitA),
        .ex_fwd_hit_b_o  (exHitB)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic                  v;
        logic [XLEN-1:0]       rd1, rd2, imm, pc;
        logic [REG_ADDR_W-1:0] rs1, rs2;
        logic [1:0]            sa, sb;
    } bundle_t;

    bundle_t m;

    // Returns {hit, value}: the first (youngest) valid source writing rs.
    function automatic logic [XLEN:0] resolve(input logic [REG_ADDR_W-1:0] rs,
                                              input logic [XLEN-1:0] regv);
        for (int k = 0; k < NUM_FWD; k++) begin
            if (fValid[k] && fRd[k] == rs && rs != 0) return {1'b1, fData[k]};
        end
        return {1'b0, regv};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [XLEN:0] ra, rb;
        if (!rst_n) begin
            m <= '0;
        end else begin
            ra = resolve(m.rs1, m.rd1);
            rb = resolve(m.rs2, m.rd2);
            if (flush) begin
                m <= '0;
            end else if (stall) begin
                if (m.v && ra[XLEN]) m.rd1 <= ra[XLEN-1:0];
                if (m.v && rb[XLEN]) m.rd2 <= rb[XLEN-1:0];
            end else begin
                m <= '{v: idValid, rd1: idRd1, rd2: idRd2, imm: idImm, pc: idPc,
                       rs1: idRs1, rs2: idRs2, sa: idSelA, sb: idSelB};
            end
        end
    end

    task automatic check(input string name, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        logic [XLEN:0]   ra, rb;
        logic [XLEN-1:0] eA, eB, eW;
        logic            hA, hB;
        ra = resolve(m.rs1, m.rd1);
        rb = resolve(m.rs2, m.rd2);
        eA = (m.sa == 0) ? ra[XLEN-1:0] : (m.sa == 1) ? m.pc : '0;
        eB = (m.sb == 0) ? rb[XLEN-1:0] : (m.sb == 1) ? m.imm :
             (m.sb == 2) ? 32'd4 : '0;
        eW = rb[XLEN-1:0];
        hA = (m.sa == 0) && ra[XLEN];
        hB = rb[XLEN];
        if (!m.v) begin
            eA = '0; eB = '0; eW = '0; hA = 1'b0; hB = 1'b0;
        end
        check("mdl_valid", 32'(exValid), 32'(m.v));
        check("mdl_srcA",  exSrcA, eA);
        check("mdl_srcB",  exSrcB, eB);
        check("mdl_wdata", exWd, eW);
        check("mdl_hitA",  32'(exHitA), 32'(hA));
        check("mdl_hitB",  32'(exHitB), 32'(hB));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadId(input logic v, input logic [XLEN-1:0] rd1,
                          input logic [XLEN-1:0] rd2, input logic [XLEN-1:0] imm,
                          input logic [XLEN-1:0] pc, input logic [REG_ADDR_W-1:0] rs1,
                          input logic [REG_ADDR_W-1:0] rs2, input logic [1:0] sa,
                          input logic [1:0] sb);
        idValid = v; idRd1 = rd1; idRd2 = rd2; idImm = imm; idPc = pc;
        idRs1 = rs1; idRs2 = rs2; idSelA = sa; idSelB = sb;
    endtask

    task automatic clearFwd();
        fValid = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            fRd[k]   = '0;
            fData[k] = '0;
        end
    endtask

    initial begin
        clearFwd();
        // Reset state
        #3;
        check("rst_valid", 32'(exValid), 32'd0);
        check("rst_srcA", exSrcA, 32'd0);
        check("rst_hitB", 32'(exHitB), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Simple load
        loadId(1'b1, 32'h11, 32'h22, 32'h0, 32'h0, 5'd0, 5'd0, 2'd0, 2'd0);
        tick();
        check("load_srcA", exSrcA, 32'h11);

        // Priority forward
        loadId(1'b1, 32'h123, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 2'd0, 2'd0);
        tick();
        fValid = 2'b11; fRd[0] = 5'd5; fRd[1] = 5'd5;
        fData[0] = 32'hAAAA; fData[1] = 32'hBBBB;
        #1;
        check("prio_src0", exSrcA, 32'hAAAA);
        check("prio_hitA", 32'(exHitA), 32'd1);
        fValid = 2'b10;
        #1;
        check("prio_src1", exSrcA, 32'hBBBB);
        clearFwd();

        // x0 never forwards
        loadId(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'd0, 2'd0);
        tick();
        fValid = 2'b01; fRd[0] = 5'd0; fData[0] = 32'hDEAD;
        #1;
        check("x0_wdata", exWd, 32'h0);
        check("x0_hitB", 32'(exHitB), 32'd0);
        clearFwd();

        // Refresh on stall
        loadId(1'b1, 32'h1, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0, 2'd0, 2'd0);
        tick();
        stall = 1'b1;
        loadId(1'b1, 32'h999, 32'h0, 32'h0, 32'h0, 5'd9, 5'd0, 2'd0, 2'd0);
        fValid = 2'b10; fRd[1] = 5'd3; fData[1] = 32'h77;
        tick();
        clearFwd();
        #1;
        check("refresh_srcA", exSrcA, 32'h77);
        stall = 1'b0;
        loadId(1'b1, 32'h55, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'd0, 2'd0);
        tick();
        check("refresh_release", exSrcA, 32'h55);

        // Flush beats stall
        flush = 1'b1; stall = 1'b1;
        tick();
        check("flush_valid", 32'(exValid), 32'd0);
        check("flush_srcA", exSrcA, 32'd0);
        check("flush_wdata", exWd, 32'd0);
        flush = 1'b0; stall = 1'b0;

        // Mux selects
        loadId(1'b1, 32'h0, 32'h0, 32'h0, 32'h1000, 5'd0, 5'd0, 2'd1, 2'd0);
        tick();
        check("selA_pc", exSrcA, 32'h1000);
        loadId(1'b1, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h0, 5'd0, 5'd0, 2'd0, 2'd1);
        tick();
        check("selB_imm", exSrcB, 32'hFFFFFFF0);
        loadId(1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 2'd0, 2'd2);
        tick();
        check("selB_four", exSrcB, 32'd4);
        loadId(1'b1, 32'h0, 32'h4242, 32'h0, 32'h0, 5'd0, 5'd6, 2'd0, 2'd3);
        tick();
        check("selB_rsvd", exSrcB, 32'd0);
        check("selB_rsvd_wd", exWd, 32'h4242);
        fValid = 2'b01; fRd[0] = 5'd6; fData[0] = 32'h6666;
        #1;
        check("selB_rsvd_fwd_wd", exWd, 32'h6666);
        check("selB_rsvd_hitB", 32'(exHitB), 32'd1);
        clearFwd();

        // Asynchronous reset mid-stream, while stalled with a valid bundle
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(exValid), 32'd0);
        check("async_rst_wd", exWd, 32'd0);
        tick();
        rst_n = 1'b1;
        stall = 1'b0;

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            loadId($urandom_range(0, 7) != 0, $urandom, $urandom, $urandom, $urandom,
                   REG_ADDR_W'($urandom_range(0, 7)), REG_ADDR_W'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            stall  = ($urandom_range(0, 3) == 0);
            flush  = ($urandom_range(0, 11) == 0);
            fValid = NUM_FWD'($urandom);
            for (int k = 0; k < NUM_FWD; k++) begin
                fRd[k]   = REG_ADDR_W'($urandom_range(0, 7));
                fData[k] = $urandom;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ex_operand_stage
`default_nettype wire

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- Parametrised successor to the single 2:1 ALU source-B select.
- Registers the ID/EX operand bundle, then resolves forwarding from NUM_FWD later pipeline stages with fixed priority.
- Drives ALU SrcA/SrcB and the store WriteData.
- Holds state under stall, bubbles on flush, and captures forwarded values while stalled so a retiring producer is not lost.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width
NUM_FWD, 2, number of forwarding sources; index 0 = youngest (EX/MEM), highest priority

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid_i  in  1  ID stage holds a valid instruction
stall_i  in  1  hold EX register contents
flush_i  in  1  kill EX contents (insert bubble)
id_rd1_i  in  XLEN  register-file read port 1
id_rd2_i  in  XLEN  register-file read port 2
id_imm_i  in  XLEN  extended immediate
id_pc_i  in  XLEN  instruction PC
id_rs1_i  in  REG_ADDR_W  source register 1 index
id_rs2_i  in  REG_ADDR_W  source register 2 index
id_src_a_sel_i  in  2  SrcA select: 0 reg, 1 PC, 2 zero, 3 reserved
id_src_b_sel_i  in  2  SrcB select: 0 reg, 1 imm, 2 constant 4, 3 reserved
fwd_valid_i  in  NUM_FWD  per-source write-enable
fwd_rd_i  in  NUM_FWD*REG_ADDR_W  per-source destination index, packed; source k at [k*REG_ADDR_W +: REG_ADDR_W]
fwd_data_i  in  NUM_FWD*XLEN  per-source result, packed likewise
ex_valid_o  out  1  EX holds a valid instruction
ex_src_a_o  out  XLEN  ALU operand A
ex_src_b_o  out  XLEN  ALU operand B
ex_write_data_o  out  XLEN  forwarded rs2 value for stores
ex_fwd_hit_a_o  out  1  rs1 resolved from a forwarding source this cycle
ex_fwd_hit_b_o  out  1  rs2 resolved from a forwarding source this cycle

Behaviour:
- Registered state: valid_q, rd1_q, rd2_q, imm_q, pc_q, rs1_q, rs2_q, sel_a_q, sel_b_q. All reset asynchronously to 0 on rst_n low, including mid-stall.
- Output reset values:
  - ex_valid_o = 0 and all data outputs = 0.
  - Hit flags = 0, because rs1_q = rs2_q = 0 and x0 never hits.
- Update priority each rising edge: flush_i > stall_i > load.
  - flush_i = 1: valid_q <= 0; all other registers are don't-care and are cleared to 0. A simultaneous stall_i is ignored.
  - stall_i = 1 and flush_i = 0: all registers hold, except rd1_q/rd2_q load the forwarded value when valid_q = 1 and the corresponding hit is asserted (refresh-on-stall).
  - Otherwise: load every register from id_*; valid_q <= id_valid_i.
- Latency: 1 cycle, ID inputs to EX outputs. Forwarding is combinational, same-cycle from fwd_* to outputs.
- Hit rules:
  - Source k matches rs1 when fwd_valid_i[k] = 1, fwd_rd_i[k] == rs1_q, and rs1_q != 0.
  - The lowest-index match wins. Register x0 never forwards.
  - rs2 uses the same rules against rs2_q.
- Operand values:
  - fwd_a = matching source data if hit, else rd1_q.
  - fwd_b = matching source data if hit, else rd2_q.
- SrcA mux: sel 0 -> fwd_a, 1 -> pc_q, 2 -> 0, 3 -> 0.
- SrcB mux: sel 0 -> fwd_b, 1 -> imm_q, 2 -> XLEN'd4, 3 -> 0.
- ex_write_data_o = fwd_b regardless of sel_b_q.
- Output gating when valid_q = 0:
  - ex_src_a_o, ex_src_b_o and ex_write_data_o forced to 0.
  - Hit flags forced to 0.
- Hit flags assert only when the register path is selected and valid: ex_fwd_hit_a_o requires sel_a_q == 0; ex_fwd_hit_b_o reflects rs2 regardless of sel_b_q, because of the store path.
- No arithmetic beyond the compares; all widths are exact XLEN with no truncation.

Decomposition:
- Shared package ex_pkg:
  - src_a_sel_e: SRCA_REG, SRCA_PC, SRCA_ZERO, SRCA_RSVD.
  - src_b_sel_e: SRCB_REG, SRCB_IMM, SRCB_FOUR, SRCB_RSVD.
  - SRCB_CONST_FOUR = 4.
- One sub-module, fwd_priority_sel:
  - Inputs: rs index, regfile value, fwd_* buses.
  - Outputs: selected value and hit flag.
  - Contains the parametrised lowest-index-wins loop.
  - Instantiated twice, for rs1 and rs2.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with valid_q = 1 -> ex_valid_o = 0, all outputs 0 immediately, without waiting for a clock edge. Release, load id_rd1 = 0x11, sel_a = 0 -> next cycle ex_src_a_o = 0x11.
- Priority forward: rs1_q = 5, fwd_valid = 2'b11, fwd_rd = {5, 5}, fwd_data[0] = 0xAAAA, fwd_data[1] = 0xBBBB -> ex_src_a_o = 0xAAAA, hit_a = 1. With fwd_valid = 2'b10 -> 0xBBBB.
- x0 guard: rs2_q = 0, fwd_rd[0] = 0, fwd_valid[0] = 1, data 0xDEAD, rd2_q = 0 -> ex_write_data_o = 0, hit_b = 0.
- Refresh-on-stall:
  - Setup: stall_i = 1, rs1_q = 3, rd1_q = 0x1, fwd source 1 writes rd 3 with 0x77 for one cycle.
  - Next cycle: fwd_valid = 0 -> ex_src_a_o = 0x77.
  - Release stall -> new ID bundle loads.
- Flush vs stall: flush_i = 1 and stall_i = 1 together -> next cycle ex_valid_o = 0, outputs 0.
- Mux selects:
  - sel_a = 1, pc = 0x1000 -> ex_src_a_o = 0x1000.
  - sel_b = 1, imm = 0xFFFFFFF0 -> ex_src_b_o = 0xFFFFFFF0.
  - sel_b = 2 -> 4.
  - sel_b = 3 -> 0, with ex_write_data_o still equal to the forwarded rs2.
